// File: rtl/fp_norm_pkg.sv
// Shared types and constants for the FP normalization sequencer.
//   EXP_W / MANT_W : exponent and normalized significand widths
//   s1_t           : stage-1 pipeline record (detector result + operands)
//   flags_t        : result classification flags
package fp_norm_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 16;

  // All-ones exponent encodes inf; one below it is the largest finite value
  // that a carry-out would push into inf.
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [EXP_W-1:0] EXP_OVF = EXP_MAX - 1'b1;
  localparam logic [EXP_W-1:0] EXP_ONE = 1;

  typedef struct packed {
    logic              carry;
    logic              zero;
    logic [3:0]        pos;
    logic [MANT_W:0]   mant;
    logic [EXP_W-1:0]  exp;
    logic              sticky;
  } s1_t;

  typedef struct packed {
    logic zero;
    logic ovf;
    logic unf;
  } flags_t;

endpackage

// File: rtl/fp_norm_seq_lopd.sv
// LOPD_16bit: combinational leading-one position detector.
//   i_data  in  16  value to scan
//   o_pos   out 4   bit index of the most significant 1 (0 when i_data == 0)
//   o_zero  out 1   i_data is all zeros
module LOPD_16bit (
  input  logic [15:0] i_data,
  output logic [3:0]  o_pos,
  output logic        o_zero
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    o_pos  = 4'd0;
    o_zero = (i_data == 16'd0);
    // Ascending scan: the last hit, i.e. the highest set bit, wins.
    for (int i = 0; i < 16; i++) begin
      if (i_data[i]) o_pos = 4'(i);
    end
  end

endmodule

// File: rtl/fp_norm_seq.sv
// fp_norm_seq: two-stage normalization sequencer between the significand
// adder and the rounding stage.
//   i_clk, i_rst_n       clock (rising edge), async active-low reset
//   i_flush              synchronous clear of both pipeline stages
//   i_valid / o_ready    input handshake (i_mant, i_exp, i_sticky)
//   o_valid / i_ready    output handshake (o_mant, o_exp, o_sticky, flags)
//   o_zero / o_ovf / o_unf   result is zero / overflowed to inf / flushed
// Stage 1 registers the operands with the leading-one position; stage 2
// shifts, adjusts the exponent and classifies, registering to the outputs.
module fp_norm_seq
  import fp_norm_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [MANT_W:0]   i_mant,
  input  logic [EXP_W-1:0]  i_exp,
  input  logic              i_sticky,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [MANT_W-1:0] o_mant,
  output logic [EXP_W-1:0]  o_exp,
  output logic              o_sticky,
  output logic              o_zero,
  output logic              o_ovf,
  output logic              o_unf
);

  s1_t  s1_q;
  logic s1_valid;
  logic s2_valid;
  logic s2_adv;
  logic accept;

  logic [3:0] lopd_pos;
  logic       lopd_zero;

  LOPD_16bit u_lopd (
    .i_data (i_mant[MANT_W-1:0]),
    .o_pos  (lopd_pos),
    .o_zero (lopd_zero)
  );

  assign s2_adv  = ~s2_valid | i_ready;
  // Gated by reset so every output reads 0 while reset is held.
  assign o_ready = i_rst_n & (~s1_valid | s2_adv);
  assign accept  = i_valid & o_ready;
  assign o_valid = s2_valid;

  // Stage 1
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      // NOTE: data registers are reset too; the pipeline is a few flops, not
      // a memory, and a known value keeps outputs clean after reset.
      s1_q     <= '0;
    end else begin
      if (i_flush)      s1_valid <= 1'b0;
      else if (o_ready) s1_valid <= i_valid;
      if (accept) begin
        s1_q.carry  <= i_mant[MANT_W];
        s1_q.zero   <= lopd_zero;
        s1_q.pos    <= lopd_pos;
        s1_q.mant   <= i_mant;
        s1_q.exp    <= i_exp;
        s1_q.sticky <= i_sticky;
      end
    end
  end

  // Stage 2 result logic
  logic [3:0]        lz;
  logic [EXP_W-1:0]  lz_ext;
  logic [MANT_W-1:0] res_mant;
  logic [EXP_W-1:0]  res_exp;
  logic              res_sticky;
  flags_t            res_flags;

  assign lz     = 4'd15 - s1_q.pos;
  assign lz_ext = {{(EXP_W-4){1'b0}}, lz};

  always_comb begin
    res_mant   = '0;
    res_exp    = '0;
    res_sticky = s1_q.sticky;
    res_flags  = '0;
    if (s1_q.carry) begin
      // An already-saturated exponent also overflows rather than wrapping.
      if (s1_q.exp >= EXP_OVF) begin
        res_flags.ovf = 1'b1;
        res_exp       = EXP_MAX;
      end else begin
        res_mant   = s1_q.mant[MANT_W:1];
        res_exp    = s1_q.exp + EXP_ONE;
        res_sticky = s1_q.sticky | s1_q.mant[0];
      end
    end else if (s1_q.zero) begin
      res_flags.zero = 1'b1;
    end else if (s1_q.exp > lz_ext) begin
      res_mant = s1_q.mant[MANT_W-1:0] << lz;
      res_exp  = s1_q.exp - lz_ext;
    end else begin
      // Normalizing would drive the exponent to 0 or below: flush to zero.
      res_flags.unf  = 1'b1;
      res_flags.zero = 1'b1;
    end
  end

  // Stage 2 / output registers: hold everything while stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid <= 1'b0;
      o_mant   <= '0;
      o_exp    <= '0;
      o_sticky <= 1'b0;
      o_zero   <= 1'b0;
      o_ovf    <= 1'b0;
      o_unf    <= 1'b0;
    end else if (i_flush) begin
      s2_valid <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        o_mant   <= res_mant;
        o_exp    <= res_exp;
        o_sticky <= res_sticky;
        o_zero   <= res_flags.zero;
        o_ovf    <= res_flags.ovf;
        o_unf    <= res_flags.unf;
      end
    end
  end

endmodule
